// File: rtl/bsearch_controller_if.sv
// Bus bundle between the binary-search controller and the logic around it.
// Groups the start/done handshake, the search target and result, and the
// RAM read port (address out, data back) into one connection.
//   start     level request from the switch/key logic
//   target    value to search for
//   ram_q     RAM read data returned to the controller
//   ram_addr  RAM read address driven by the controller
//   busy      search in progress
//   done      search finished, result valid
//   found     target present (valid while done)
//   loc       index of the match (valid while done && found)
// Modports: slave = the controller, master = the surrounding system
// (request source plus RAM instance).
interface bsearch_controller_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] target;
  logic [DATA_W-1:0] ram_q;
  logic [ADDR_W-1:0] ram_addr;
  logic              busy;
  logic              done;
  logic              found;
  logic [ADDR_W-1:0] loc;

  modport slave (
    input  start, target, ram_q,
    output ram_addr, busy, done, found, loc
  );

  modport master (
    output start, target, ram_q,
    input  ram_addr, busy, done, found, loc
  );
endinterface

// File: rtl/bsearch_controller.sv
// Binary search sequencer for a sorted, ascending, synchronous-read RAM of
// 2^ADDR_W words. Each probe presents mid=(lo+hi)>>1 on the RAM address,
// waits RD_LAT cycles for the read data, compares it with the latched target
// and narrows the lo/hi window until a match or an empty window.
// Ports:
//   CLOCK_50  system clock, all state updates on its rising edge
//   reset     synchronous, active-high reset
//   bus       bsearch_controller_if slave modport (start/target/ram_q in,
//             ram_addr/busy/done/found/loc out)
// Parameters: ADDR_W address width, DATA_W word width, RD_LAT read latency
// (1..4 cycles from ram_addr change to valid ram_q).
module bsearch_controller #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  bsearch_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    CMP,
    DONE
  } state_t;

  // WAIT counts down from RD_LAT-2 to 0, giving RD_LAT-1 WAIT cycles.
  localparam logic [1:0] WAIT_LOAD = (RD_LAT >= 2) ? 2'(RD_LAT - 2) : 2'd0;

  state_t            ps;
  logic [ADDR_W-1:0] lo;
  logic [ADDR_W-1:0] hi;
  logic [ADDR_W-1:0] loc_r;
  logic              found_r;
  logic [DATA_W-1:0] target_r;
  logic [1:0]        wait_cnt;
  logic [ADDR_W-1:0] mid;
  logic [ADDR_W-1:0] addr_mux;

  // Sum is widened by one bit so lo+hi near the top of the space cannot wrap.
  assign mid = ADDR_W'(({1'b0, lo} + {1'b0, hi}) >> 1);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      ps       <= IDLE;
      lo       <= '0;
      hi       <= '1;
      found_r  <= 1'b0;
      loc_r    <= '0;
      wait_cnt <= '0;
      target_r <= '0;
    end else begin
      case (ps)
        IDLE: begin
          if (bus.start) begin
            target_r <= bus.target;
            lo       <= '0;
            hi       <= '1;
            found_r  <= 1'b0;
            loc_r    <= '0;
            ps       <= ADDR;
          end
        end
        ADDR: begin
          if (RD_LAT == 1) begin
            ps <= CMP;
          end else begin
            wait_cnt <= WAIT_LOAD;
            ps       <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == 2'd0) begin
            ps <= CMP;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        CMP: begin
          // The mid==hi / mid==lo tests end the search on an empty window
          // instead of letting lo/hi step past each other and wrap.
          if (bus.ram_q == target_r) begin
            found_r <= 1'b1;
            loc_r   <= mid;
            ps      <= DONE;
          end else if (bus.ram_q < target_r) begin
            if (mid == hi) begin
              found_r <= 1'b0;
              ps      <= DONE;
            end else begin
              lo <= mid + ADDR_W'(1);
              ps <= ADDR;
            end
          end else begin
            if (mid == lo) begin
              found_r <= 1'b0;
              ps      <= DONE;
            end else begin
              hi <= mid - ADDR_W'(1);
              ps <= ADDR;
            end
          end
        end
        DONE: begin
          // A new search needs start to drop first, so a held key does
          // not retrigger.
          if (!bus.start) begin
            ps <= IDLE;
          end
        end
        default: ps <= IDLE;
      endcase
    end
  end

  always_comb begin
    addr_mux = '0;
    case (ps)
      ADDR, WAIT, CMP: addr_mux = mid;
      DONE:            addr_mux = loc_r;
      default:         addr_mux = '0;
    endcase
  end

  assign bus.ram_addr = addr_mux;
  assign bus.busy     = (ps == ADDR) || (ps == WAIT) || (ps == CMP);
  assign bus.done     = (ps == DONE);
  assign bus.found    = found_r;
  assign bus.loc      = loc_r;

endmodule

// File: tb/tb_bsearch_controller.sv
// Testbench for bsearch_controller. Three instances with RD_LAT = 1, 2 and 4
// share one RAM image; each has its own read pipeline of matching depth.
// Results are checked against a reference search done directly over the RAM
// image (linear scan), plus latency bounds derived from the probe count.
module tb_bsearch_controller;

  logic       clk;
  logic       reset;
  logic       start_s  [3];
  logic [7:0] target_s [3];
  logic [7:0] mem [32];
  logic [7:0] p1 [1];
  logic [7:0] p2 [2];
  logic [7:0] p4 [4];

  int n_checks;
  int n_fail;

  bsearch_controller_if #(.ADDR_W(5), .DATA_W(8)) ifc1 ();
  bsearch_controller_if #(.ADDR_W(5), .DATA_W(8)) ifc2 ();
  bsearch_controller_if #(.ADDR_W(5), .DATA_W(8)) ifc4 ();

  bsearch_controller #(.ADDR_W(5), .DATA_W(8), .RD_LAT(1)) dut1 (
    .CLOCK_50(clk), .reset(reset), .bus(ifc1.slave));
  bsearch_controller #(.ADDR_W(5), .DATA_W(8), .RD_LAT(2)) dut2 (
    .CLOCK_50(clk), .reset(reset), .bus(ifc2.slave));
  bsearch_controller #(.ADDR_W(5), .DATA_W(8), .RD_LAT(4)) dut4 (
    .CLOCK_50(clk), .reset(reset), .bus(ifc4.slave));

  assign ifc1.start  = start_s[0];
  assign ifc2.start  = start_s[1];
  assign ifc4.start  = start_s[2];
  assign ifc1.target = target_s[0];
  assign ifc2.target = target_s[1];
  assign ifc4.target = target_s[2];
  assign ifc1.ram_q  = p1[0];
  assign ifc2.ram_q  = p2[1];
  assign ifc4.ram_q  = p4[3];

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Synchronous-read RAM: data for an address appears RD_LAT edges later.
  always_ff @(posedge clk) begin
    p1[0] <= mem[ifc1.ram_addr];
    p2[0] <= mem[ifc2.ram_addr];
    p2[1] <= p2[0];
    p4[0] <= mem[ifc4.ram_addr];
    p4[1] <= p4[0];
    p4[2] <= p4[1];
    p4[3] <= p4[2];
  end

  function automatic int lat_of(input int w);
    return (w == 0) ? 1 : (w == 1) ? 2 : 4;
  endfunction

  // {busy, done, found, loc[4:0], ram_addr[4:0]}
  function automatic logic [12:0] snap(input int w);
    case (w)
      0:       return {ifc1.busy, ifc1.done, ifc1.found, ifc1.loc, ifc1.ram_addr};
      1:       return {ifc2.busy, ifc2.done, ifc2.found, ifc2.loc, ifc2.ram_addr};
      default: return {ifc4.busy, ifc4.done, ifc4.found, ifc4.loc, ifc4.ram_addr};
    endcase
  endfunction

  function automatic int ref_find(input logic [7:0] tgt);
    for (int i = 0; i < 32; i++) begin
      if (mem[i] == tgt) return i;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Raise start with a target and wait (bounded) for done.
  task automatic applyStimulus(input int w, input logic [7:0] tgt,
                               output int lat, output logic [4:0] first_addr);
    logic [12:0] s;
    int bound;
    bound = 6 * (lat_of(w) + 1) + 1;
    @(negedge clk);
    target_s[w] = tgt;
    start_s[w]  = 1'b1;
    lat = 0;
    first_addr = '0;
    for (int i = 0; i < bound + 4; i++) begin
      @(posedge clk);
      #1;
      lat++;
      s = snap(w);
      if (lat == 1) first_addr = s[4:0];
      if (s[11]) break;
    end
    s = snap(w);
    checkOutput($sformatf("done_reached_L%0d_t%0d", lat_of(w), tgt), 32'(s[11]), 32'd1);
    checkOutput($sformatf("latency_bound_L%0d_t%0d", lat_of(w), tgt),
                32'(lat <= bound), 32'd1);
  endtask

  task automatic releaseStart(input int w);
    logic [12:0] s;
    @(negedge clk);
    start_s[w] = 1'b0;
    @(posedge clk);
    #1;
    s = snap(w);
    checkOutput($sformatf("idle_done_L%0d", lat_of(w)), 32'(s[11]), 32'd0);
    checkOutput($sformatf("idle_busy_L%0d", lat_of(w)), 32'(s[12]), 32'd0);
  endtask

  // Full search plus result check against the reference scan.
  // exact_loc: RAM values unique, so the index itself is checked.
  task automatic searchAndCheck(input int w, input logic [7:0] tgt, input bit exact_loc);
    int lat;
    int idx;
    logic [4:0] fa;
    logic [12:0] s;
    applyStimulus(w, tgt, lat, fa);
    s = snap(w);
    idx = ref_find(tgt);
    checkOutput($sformatf("found_L%0d_t%0d", lat_of(w), tgt), 32'(s[10]), 32'(idx >= 0));
    if (idx >= 0) begin
      checkOutput($sformatf("mem_at_loc_L%0d_t%0d", lat_of(w), tgt), 32'(mem[s[9:5]]), 32'(tgt));
      checkOutput($sformatf("mem_at_addr_L%0d_t%0d", lat_of(w), tgt), 32'(mem[s[4:0]]), 32'(tgt));
      if (exact_loc)
        checkOutput($sformatf("loc_L%0d_t%0d", lat_of(w), tgt), 32'(s[9:5]), 32'(idx));
    end else begin
      checkOutput($sformatf("loc_absent_L%0d_t%0d", lat_of(w), tgt), 32'(s[9:5]), 32'd0);
      checkOutput($sformatf("addr_absent_L%0d_t%0d", lat_of(w), tgt), 32'(s[4:0]), 32'd0);
    end
    releaseStart(w);
  endtask

  // Target at the first probe (mid=15 with RAM[i]=2*i): exact best-case timing.
  task automatic firstProbeHit(input int w);
    int lat;
    logic [4:0] fa;
    logic [12:0] s;
    applyStimulus(w, 8'd30, lat, fa);
    s = snap(w);
    checkOutput($sformatf("first_probe_addr_L%0d", lat_of(w)), 32'(fa), 32'd15);
    checkOutput($sformatf("best_latency_L%0d", lat_of(w)), 32'(lat), 32'(lat_of(w) + 2));
    checkOutput($sformatf("best_found_L%0d", lat_of(w)), 32'(s[10]), 32'd1);
    checkOutput($sformatf("best_loc_L%0d", lat_of(w)), 32'(s[9:5]), 32'd15);
    checkOutput($sformatf("best_addr_L%0d", lat_of(w)), 32'(s[4:0]), 32'd15);
    releaseStart(w);
  endtask

  initial begin
    logic [12:0] s;
    int v;
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 3; i++) begin
      start_s[i]  = 1'b0;
      target_s[i] = '0;
    end
    for (int i = 0; i < 32; i++) mem[i] = 8'(2 * i);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int w = 0; w < 3; w++) begin
      s = snap(w);
      checkOutput($sformatf("reset_outputs_L%0d", lat_of(w)), 32'(s), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] directed searches, RAM[i]=2*i");
    firstProbeHit(1);
    searchAndCheck(1, 8'd20, 1'b1);
    searchAndCheck(1, 8'd0,  1'b1);
    searchAndCheck(1, 8'd62, 1'b1);
    searchAndCheck(1, 8'd21, 1'b1);
    searchAndCheck(1, 8'd63, 1'b1);
    searchAndCheck(1, 8'd1,  1'b1);

    $display("[TB] hold start after done");
    begin
      int lat;
      logic [4:0] fa;
      applyStimulus(1, 8'd30, lat, fa);
      repeat (50) @(posedge clk);
      #1;
      s = snap(1);
      checkOutput("held_done", 32'(s[11]), 32'd1);
      checkOutput("held_found", 32'(s[10]), 32'd1);
      checkOutput("held_loc", 32'(s[9:5]), 32'd15);
      releaseStart(1);
      searchAndCheck(1, 8'd8, 1'b1);
    end

    $display("[TB] reset during third probe wait");
    @(negedge clk);
    target_s[1] = 8'd21;
    start_s[1]  = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    s = snap(1);
    checkOutput("mid_search_busy", 32'(s[12]), 32'd1);
    reset = 1'b1;
    start_s[1] = 1'b0;
    @(posedge clk);
    #1;
    s = snap(1);
    checkOutput("reset_mid_search", 32'(s), 32'd0);
    reset = 1'b0;
    searchAndCheck(1, 8'd40, 1'b1);

    $display("[TB] other read latencies");
    firstProbeHit(0);
    searchAndCheck(0, 8'd63, 1'b1);
    firstProbeHit(2);
    searchAndCheck(2, 8'd63, 1'b1);

    $display("[TB] random sorted RAM contents");
    for (int k = 0; k < 12; k++) begin
      v = int'($urandom_range(0, 20));
      for (int i = 0; i < 32; i++) begin
        if (i > 0) v = v + int'($urandom_range(0, 15));
        mem[i] = (v > 255) ? 8'd255 : 8'(v);
      end
      for (int w = 0; w < 3; w++) begin
        if ($urandom_range(0, 1) == 1)
          searchAndCheck(w, mem[$urandom_range(0, 31)], 1'b0);
        else
          searchAndCheck(w, 8'($urandom_range(0, 255)), 1'b0);
      end
    end

    $display("[TB] random unsorted RAM contents, termination only");
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom_range(0, 255));
      for (int w = 0; w < 3; w++) begin
        int lat;
        logic [4:0] fa;
        logic [7:0] tgt;
        tgt = mem[$urandom_range(0, 31)];
        applyStimulus(w, tgt, lat, fa);
        s = snap(w);
        if (s[10])
          checkOutput($sformatf("unsorted_match_L%0d", lat_of(w)), 32'(mem[s[9:5]]), 32'(tgt));
        releaseStart(w);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
